// File: rtl/wb_master_engine_if.sv
// Command/response and Wishbone bus signals for wb_master_engine.
// The master modport is the engine's view; slave is the view of the environment driving it.
interface wb_master_engine_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic                  cmd_irq;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  busy;
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  irq_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_irq, cmd_addr, cmd_data, ack_i, dat_i, irq_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        output cyc_o, stb_o, we_o, adr_o, dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_irq, cmd_addr, cmd_data, ack_i, dat_i, irq_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  cyc_o, stb_o, we_o, adr_o, dat_o
    );
endinterface

// File: rtl/wb_master_engine.sv
// Queued Wishbone master: commands go through a small FIFO, each becomes one bus cycle
// (with timeout) or an interrupt wait, and each yields one response pulse.
module wb_master_engine #(
    parameter int unsigned ADDR_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    wb_master_engine_if.master bus
);
    localparam int unsigned PTR_W   = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W   = $clog2(CMD_DEPTH + 1);
    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ENTRY_W = 2 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StBus, StWaitIrq, StGap} state_e;

    logic [ENTRY_W-1:0] mem_q [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               cmd_ready, push, pop;
    logic [ENTRY_W-1:0] head;
    logic               head_irq, head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               cyc_q, cyc_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    assign cmd_ready = count_q < CNT_W'(CMD_DEPTH);
    assign push      = bus.cmd_valid && cmd_ready;
    assign pop       = (state_q == StIdle) && (count_q != '0);

    assign head      = mem_q[rd_ptr_q];
    assign head_irq  = head[ENTRY_W-1];
    assign head_we   = head[ENTRY_W-2];
    assign head_addr = head[DATA_WIDTH +: ADDR_WIDTH];
    assign head_data = head[0 +: DATA_WIDTH];

    // Pointers wrap naturally since CMD_DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {bus.cmd_irq, bus.cmd_we, bus.cmd_addr, bus.cmd_data};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    if (head_irq) begin
                        state_d = StWaitIrq;
                    end else begin
                        state_d = StBus;
                        cyc_d   = 1'b1;
                        we_d    = head_we;
                        adr_d   = head_addr;
                        dat_d   = head_we ? head_data : '0;
                        timer_d = '0;
                    end
                end
            end
            StBus: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (bus.ack_i || (timer_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d     = StGap;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    timer_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !bus.ack_i;
                    rsp_data_d  = (bus.ack_i && !we_q) ? bus.dat_i : '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StWaitIrq: begin
                if (bus.irq_i) begin
                    state_d     = StGap;
                    rsp_valid_d = 1'b1;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.busy      = (state_q != StIdle) || (count_q != '0);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.cyc_o     = cyc_q;
    assign bus.stb_o     = cyc_q;
    assign bus.we_o      = we_q;
    assign bus.adr_o     = adr_q;
    assign bus.dat_o     = dat_q;
endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: a table of single bus transactions plus
// hand-written sequences for FIFO fill, interrupt wait and mid-transaction reset.
module tb_wb_master_engine;
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    wb_master_engine_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus ();

    wb_master_engine #(
        .ADDR_WIDTH    (2),
        .DATA_WIDTH    (8),
        .CMD_DEPTH     (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        int         ack_at;     // BUS edge carrying ack_i, 0 = never
        logic [7:0] rdata;
        logic [7:0] exp_dat;
        int         exp_edges;  // BUS edges until cyc_o drops
        logic       exp_err;
        logic [7:0] exp_rsp;
    } vec_t;

    vec_t vecs [6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_cmd(input logic irq, input logic we, input logic [1:0] a,
                            input logic [7:0] d);
        bus.cmd_irq   = irq;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a bus cycle, check its fields, then ack it on the next edge.
    task automatic serve(input string name, input logic [1:0] ea, input logic [7:0] ed);
        int k = 0;
        while (!bus.cyc_o && k < 20) begin
            tick();
            k++;
        end
        chk({name, "_issued"}, bus.cyc_o, 1);
        chk({name, "_adr"}, bus.adr_o, ea);
        chk({name, "_dat"}, bus.dat_o, ed);
        bus.ack_i = 1'b1;
        bus.dat_i = 8'hEE;
        tick();
        bus.ack_i = 1'b0;
        chk({name, "_rsp"}, {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {2'b10, 8'h00});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic bad;
        int   edges;
        int   k;

        vecs[0] = '{1'b1, 2'd2, 8'hA5, 3, 8'h00, 8'hA5, 3, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 2'd1, 8'h00, 1, 8'h3C, 8'h00, 1, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 2'd3, 8'h00, 0, 8'h99, 8'h00, 8, 1'b1, 8'h00};
        vecs[3] = '{1'b0, 2'd3, 8'h00, 8, 8'h5A, 8'h00, 8, 1'b0, 8'h5A};
        vecs[4] = '{1'b1, 2'd0, 8'hFF, 2, 8'h77, 8'hFF, 2, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 2'd2, 8'h12, 7, 8'h81, 8'h00, 7, 1'b0, 8'h81};

        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_irq   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.ack_i     = 1'b0;
        bus.dat_i     = '0;
        bus.irq_i     = 1'b0;
        rst_i         = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        chk("reset_cyc", bus.cyc_o, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_ready_busy", {bus.cmd_ready, bus.busy}, 2'b10);

        foreach (vecs[i]) begin
            chk($sformatf("v%0d_ready", i), bus.cmd_ready, 1);
            push_cmd(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_no_cyc_at_push", i), bus.cyc_o, 0);
            tick();
            chk($sformatf("v%0d_cyc_stb", i), {bus.cyc_o, bus.stb_o}, 2'b11);
            chk($sformatf("v%0d_adr", i), bus.adr_o, vecs[i].addr);
            chk($sformatf("v%0d_dat", i), bus.dat_o, vecs[i].exp_dat);
            chk($sformatf("v%0d_we", i), bus.we_o, vecs[i].we);
            edges = 0;
            for (int n = 1; n <= 20; n++) begin
                bus.ack_i = (n == vecs[i].ack_at);
                bus.dat_i = vecs[i].rdata;
                tick();
                bus.ack_i = 1'b0;
                if (!bus.cyc_o) begin
                    edges = n;
                    break;
                end
            end
            chk($sformatf("v%0d_bus_edges", i), edges, vecs[i].exp_edges);
            chk($sformatf("v%0d_rsp", i), {bus.rsp_valid, bus.rsp_err, bus.stb_o},
                {1'b1, vecs[i].exp_err, 1'b0});
            chk($sformatf("v%0d_rsp_data", i), bus.rsp_data, vecs[i].exp_rsp);
            tick();
            chk($sformatf("v%0d_gap", i), {bus.rsp_valid, bus.cyc_o, bus.busy}, 3'b000);
        end

        // FIFO fill while the first write hangs without ack.
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("fill%0d_ready", c), bus.cmd_ready, 1);
            push_cmd(1'b0, 1'b1, 2'(c), 8'h10 + 8'(c));
        end
        chk("fill_full", {bus.cmd_ready, bus.cyc_o, bus.adr_o}, {1'b0, 1'b1, 2'd0});
        bus.cmd_we    = 1'b1;
        bus.cmd_irq   = 1'b0;
        bus.cmd_addr  = 2'd1;
        bus.cmd_data  = 8'h15;
        bus.cmd_valid = 1'b1;
        tick();
        tick();
        chk("fill_sixth_held", bus.cmd_ready, 0);
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
        chk("fill_first_done", {bus.rsp_valid, bus.cyc_o}, 2'b10);
        k = 0;
        while (!bus.cmd_ready && k < 10) begin
            tick();
            k++;
        end
        chk("fill_ready_after_ack", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        for (int c = 1; c < 6; c++) begin
            serve($sformatf("drain%0d", c), 2'(c), 8'h10 + 8'(c));
        end
        tick();
        tick();
        chk("drain_idle", bus.busy, 0);

        // Wait-for-interrupt followed by a queued write; stray acks must be ignored.
        push_cmd(1'b1, 1'b0, 2'd0, 8'h00);
        push_cmd(1'b0, 1'b1, 2'd3, 8'hC3);
        bad = 1'b0;
        bus.ack_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            bad |= bus.cyc_o | bus.rsp_valid | !bus.busy;
        end
        bus.ack_i = 1'b0;
        chk("irq_wait_quiet", bad, 0);
        bus.irq_i = 1'b1;
        tick();
        bus.irq_i = 1'b0;
        chk("irq_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.cyc_o},
            {2'b10, 8'h00, 1'b0});
        tick();
        chk("irq_gap", {bus.cyc_o, bus.rsp_valid}, 2'b00);
        tick();
        chk("irq_then_write", {bus.cyc_o, bus.we_o, bus.adr_o, bus.dat_o},
            {2'b11, 2'd3, 8'hC3});
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
        chk("irq_write_rsp", bus.rsp_valid, 1);
        tick();

        // Reset in the middle of a bus cycle with two commands queued.
        push_cmd(1'b0, 1'b1, 2'd1, 8'h61);
        push_cmd(1'b0, 1'b1, 2'd2, 8'h62);
        push_cmd(1'b0, 1'b0, 2'd3, 8'h63);
        chk("rst_pre_cyc", bus.cyc_o, 1);
        rst_i         = 1'b1;
        bus.cmd_valid = 1'b1;
        tick();
        rst_i         = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("rst_bus_dropped", {bus.cyc_o, bus.stb_o, bus.rsp_valid}, 3'b000);
        chk("rst_ready_busy", {bus.cmd_ready, bus.busy}, 2'b10);
        bad = 1'b0;
        bus.ack_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            bad |= bus.cyc_o | bus.rsp_valid | bus.busy;
        end
        bus.ack_i = 1'b0;
        chk("rst_queue_flushed", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
